// File: rtl/fp_vec_packer.sv
// fp_vec_packer: gathers a serial FP32 stream into N-lane vectors for the
// adder tree and runs a metadata delay line so valid/last/lane-count line up
// with the tree's sum output TREE_LAT cycles later.
// Optional build macro FP_VEC_PACKER_SPECIAL_FLAG_EN adds vec_special and
// sum_special, flagging vectors with any real Inf/NaN lane.
module fp_vec_packer #(
   parameter int N        = 8,
   parameter int TREE_LAT = 3,
   parameter int CNT_W    = $clog2(N) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   input  logic             s_last,
   output logic [31:0]      vec_data [0:N-1],
   output logic             vec_valid,
   output logic             vec_last,
   output logic [CNT_W-1:0] vec_lanes,
   output logic             sum_valid,
   output logic             sum_last,
`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
   output logic [CNT_W-1:0] sum_lanes,
   output logic             vec_special,
   output logic             sum_special
`else
   output logic [CNT_W-1:0] sum_lanes
`endif
);

`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
   localparam int META_W = CNT_W + 3;
`else
   localparam int META_W = CNT_W + 2;
`endif

   typedef enum logic {EMPTY, FILLING} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] fill_count;
   logic             accept;
   logic             issue;
   logic [31:0]      gather     [0:N-1];
   logic [31:0]      lanes_next [0:N-1];
   logic [META_W-1:0] meta_in;
   logic [META_W-1:0] dly [0:TREE_LAT-1];
`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
   logic             special_next;
`endif

   // State register: fill state and the count of lanes already gathered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next state: an issue empties the buffer, a plain accept keeps filling.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (issue) begin
         state_next = EMPTY;
         cnt_next   = '0;
      end else if (accept) begin
         state_next = FILLING;
         cnt_next   = fill_count;
      end
   end

   // Output decode: handshake, issue decision and the zero-padded vector to issue.
   always_comb begin
      accept     = s_valid && s_ready;
      fill_count = cnt + CNT_W'(1);
      issue      = accept && (s_last || (fill_count == CNT_W'(N)));
      for (int i = 0; i < N; i++) begin
         lanes_next[i] = 32'h0;
         if (CNT_W'(i) < cnt) begin
            lanes_next[i] = gather[i];
         end else if (CNT_W'(i) == cnt) begin
            lanes_next[i] = s_data;
         end
      end
   end

`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
   // Special detect: any real lane with an all-ones exponent (Inf or NaN).
   always_comb begin
      special_next = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ((CNT_W'(i) < fill_count) && (lanes_next[i][30:23] == 8'hFF)) begin
            special_next = 1'b1;
         end
      end
   end
`endif

   // Ready comes up one edge after reset release and stays up; the tree never stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready <= 1'b0;
      end else begin
         s_ready <= 1'b1;
      end
   end

   // Gather buffer: each accepted element lands in the lane selected by cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            gather[i] <= 32'h0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (accept && (CNT_W'(i) == cnt)) begin
               gather[i] <= s_data;
            end
         end
      end
   end

   // Issue register: vector and its tags are captured on issue and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_valid <= 1'b0;
         vec_last  <= 1'b0;
         vec_lanes <= '0;
`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
         vec_special <= 1'b0;
`endif
         for (int i = 0; i < N; i++) begin
            vec_data[i] <= 32'h0;
         end
      end else begin
         vec_valid <= issue;
         if (issue) begin
            vec_last  <= s_last;
            vec_lanes <= fill_count;
`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
            vec_special <= special_next;
`endif
            for (int i = 0; i < N; i++) begin
               vec_data[i] <= lanes_next[i];
            end
         end
      end
   end

   // Metadata is masked by vec_valid so idle delay stages carry all zeros.
`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
   assign meta_in = {vec_valid, vec_valid & vec_last,
                     vec_lanes & {CNT_W{vec_valid}}, vec_valid & vec_special};
`else
   assign meta_in = {vec_valid, vec_valid & vec_last,
                     vec_lanes & {CNT_W{vec_valid}}};
`endif

   // Delay line: shifts every cycle so metadata tracks the tree's pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TREE_LAT; i++) begin
            dly[i] <= '0;
         end
      end else begin
         dly[0] <= meta_in;
         for (int i = 1; i < TREE_LAT; i++) begin
            dly[i] <= dly[i-1];
         end
      end
   end

`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
   assign {sum_valid, sum_last, sum_lanes, sum_special} = dly[TREE_LAT-1];
`else
   assign {sum_valid, sum_last, sum_lanes} = dly[TREE_LAT-1];
`endif

endmodule

// File: tb/tb_fp_vec_packer.sv
// tb_fp_vec_packer: directed stimulus with a queue-based scoreboard for the
// vector issue and the delayed sum metadata of fp_vec_packer.
module tb_fp_vec_packer;

   localparam int N        = 8;
   localparam int TREE_LAT = 3;
   localparam int CNT_W    = $clog2(N) + 1;

   typedef struct {
      logic [32*N-1:0] data;
      logic [CNT_W-1:0] lanes;
      logic             last;
      logic             special;
      int               cyc;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             s_valid;
   logic             s_ready;
   logic [31:0]      s_data;
   logic             s_last;
   logic [31:0]      vec_data [0:N-1];
   logic             vec_valid;
   logic             vec_last;
   logic [CNT_W-1:0] vec_lanes;
   logic             sum_valid;
   logic             sum_last;
   logic [CNT_W-1:0] sum_lanes;
`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
   logic             vec_special;
   logic             sum_special;
`endif

   exp_t             vec_q [$];
   exp_t             sum_q [$];
   logic [31:0]      mbuf [0:N-1];
   int               mcnt;
   int               ncyc;
   logic [32*N-1:0]  held_data;
   int               total;
   int               passed;
   int               fails;

   fp_vec_packer #(.N(N), .TREE_LAT(TREE_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .vec_data   (vec_data),
      .vec_valid  (vec_valid),
      .vec_last   (vec_last),
      .vec_lanes  (vec_lanes),
      .sum_valid  (sum_valid),
      .sum_last   (sum_last),
`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
      .sum_lanes  (sum_lanes),
      .vec_special(vec_special),
      .sum_special(sum_special)
`else
      .sum_lanes  (sum_lanes)
`endif
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [32*N-1:0] flatVec();
      logic [32*N-1:0] f;
      for (int i = 0; i < N; i++) f[i*32 +: 32] = vec_data[i];
      return f;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkVector(input string tag, input logic [32*N-1:0] obs, input logic [32*N-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of input; on an accepted element the model gathers it and
   // schedules the expected vector and sum outputs by sample index.
   task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic last);
      exp_t e;
      s_valid = valid;
      s_data  = data;
      s_last  = last;
      @(posedge clk);
      #1;
      if (valid) begin
         mbuf[mcnt] = data;
         mcnt++;
         if (mcnt == N || last) begin
            e.data    = '0;
            e.special = 1'b0;
            for (int i = 0; i < mcnt; i++) begin
               e.data[i*32 +: 32] = mbuf[i];
               if (mbuf[i][30:23] == 8'hFF) e.special = 1'b1;
            end
            e.lanes = CNT_W'(mcnt);
            e.last  = last;
            e.cyc   = ncyc + 1;
            vec_q.push_back(e);
            e.cyc   = ncyc + 1 + TREE_LAT;
            sum_q.push_back(e);
            mcnt = 0;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Monitor: on every falling edge compare issue and sum outputs with the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         logic exp_v;
         logic exp_s;
         exp_t e;
         ncyc++;
         exp_v = (vec_q.size() > 0) && (vec_q[0].cyc == ncyc);
         checkOutput("vec_valid", 64'(vec_valid), 64'(exp_v));
         if (exp_v) begin
            e = vec_q.pop_front();
            checkVector("vec_data", flatVec(), e.data);
            checkOutput("vec_lanes", 64'(vec_lanes), 64'(e.lanes));
            checkOutput("vec_last", 64'(vec_last), 64'(e.last));
`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
            checkOutput("vec_special", 64'(vec_special), 64'(e.special));
`endif
            held_data = e.data;
         end else begin
            checkVector("vec_hold", flatVec(), held_data);
         end
         exp_s = (sum_q.size() > 0) && (sum_q[0].cyc == ncyc);
         checkOutput("sum_valid", 64'(sum_valid), 64'(exp_s));
         if (exp_s) begin
            e = sum_q.pop_front();
            checkOutput("sum_lanes", 64'(sum_lanes), 64'(e.lanes));
            checkOutput("sum_last", 64'(sum_last), 64'(e.last));
`ifdef FP_VEC_PACKER_SPECIAL_FLAG_EN
            checkOutput("sum_special", 64'(sum_special), 64'(e.special));
`endif
         end
      end
   end

   // Directed sequence: reset, full group, partial group, stream, gaps, specials, mid-group reset.
   initial begin
      logic [31:0] ones_to_eight [0:7];
      int k;
      ones_to_eight = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      total = 0; passed = 0; fails = 0;
      mcnt = 0; ncyc = 0; held_data = '0;
      rst_n = 1'b0; s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready", 64'(s_ready), 64'd0);
      checkOutput("rst_vec_valid", 64'(vec_valid), 64'd0);
      checkOutput("rst_vec_lanes", 64'(vec_lanes), 64'd0);
      checkOutput("rst_sum_valid", 64'(sum_valid), 64'd0);
      checkVector("rst_vec_data", flatVec(), '0);
      rst_n = 1'b1;
      checkOutput("ready_before_edge", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("ready_after_edge", 64'(s_ready), 64'd1);

      $display("[TB] single full group 1.0..8.0");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, ones_to_eight[i], i == 7);
      repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);

      $display("[TB] partial group of 3");
      applyStimulus(1'b1, 32'h40000000, 1'b0);
      applyStimulus(1'b1, 32'hBF800000, 1'b0);
      applyStimulus(1'b1, 32'h3F000000, 1'b1);
      repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);

      $display("[TB] continuous stream of 20");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'hC0000000 | 32'(i * 7 + 1), i == 19);
      repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);

      $display("[TB] gapped group of 8");
      k = 0;
      for (int t = 0; t < 64 && k < 8; t++) begin
         if (t >= 40 || $urandom_range(0, 1) == 1) begin
            applyStimulus(1'b1, 32'h41100000 + 32'(k), 1'b0);
            k++;
         end else begin
            applyStimulus(1'b0, 32'hDEADBEEF, 1'b0);
         end
      end
      repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);

      $display("[TB] special patterns");
      applyStimulus(1'b1, 32'h7FC00000, 1'b0);
      applyStimulus(1'b1, 32'h80000001, 1'b1);
      applyStimulus(1'b1, 32'h80000000, 1'b0);
      applyStimulus(1'b1, 32'h00000001, 1'b1);
      repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);

      $display("[TB] reset mid-group");
      applyStimulus(1'b1, 32'h3F800000, 1'b0);
      applyStimulus(1'b1, 32'h3F800001, 1'b0);
      applyStimulus(1'b1, 32'h3F800002, 1'b1);
      applyStimulus(1'b1, 32'h3F800003, 1'b0);
      applyStimulus(1'b1, 32'h3F800004, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      vec_q.delete();
      sum_q.delete();
      mcnt = 0;
      held_data = '0;
      checkOutput("arst_ready", 64'(s_ready), 64'd0);
      checkOutput("arst_vec_lanes", 64'(vec_lanes), 64'd0);
      checkOutput("arst_vec_last", 64'(vec_last), 64'd0);
      checkOutput("arst_sum_valid", 64'(sum_valid), 64'd0);
      checkVector("arst_vec_data", flatVec(), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready_after_reset", 64'(s_ready), 64'd1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h42000000 + 32'(i), 1'b0);
      repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
